// File: rtl/car_warning_sequencer_pkg.sv
// Shared types and default timing for the car warning sequencer.
// The state encoding is 3 bits so it can be decoded directly by other blocks.
package car_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUALIFY  = 3'd1,
    BEEP_ON  = 3'd2,
    BEEP_OFF = 3'd3,
    SILENCED = 3'd4
  } car_state_t;

  localparam int unsigned DEF_PRESCALE   = 1000;
  localparam int unsigned DEF_QUAL_TICKS = 4;
  localparam int unsigned DEF_ON_TICKS   = 2;
  localparam int unsigned DEF_OFF_TICKS  = 2;
  localparam int unsigned DEF_MAX_BEEPS  = 8;

endpackage

// File: rtl/car_warning_sequencer_tick_prescaler.sv
// Free-running cycle counter that emits one tick every PRESCALE clocks.
// A synchronous clear restarts the count so each state gets exact tick spacing.
module car_tick_prescaler
  import car_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/car_warning_sequencer.sv
// Dashboard buzzer/lamp sequencer: qualifies the warning bit, plays a timed
// beep pattern, and silences after a beep budget or a driver acknowledge.
module car_warning_sequencer
  import car_pkg::*;
#(
  parameter int unsigned PRESCALE   = DEF_PRESCALE,
  parameter int unsigned QUAL_TICKS = DEF_QUAL_TICKS,
  parameter int unsigned ON_TICKS   = DEF_ON_TICKS,
  parameter int unsigned OFF_TICKS  = DEF_OFF_TICKS,
  parameter int unsigned MAX_BEEPS  = DEF_MAX_BEEPS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       warn_in,
  input  logic       ack,
  output logic       buzzer,
  output logic       lamp,
  output logic [7:0] beep_cnt,
  output logic       silenced
);

  car_state_t  state, next_state;
  logic        tick;
  logic        state_change;
  logic        timer_done;
  logic [15:0] tick_cnt;
  logic [15:0] tick_limit;
  logic [7:0]  beep_next;

  assign state_change = (next_state != state);

  car_tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_change),
    .tick  (tick)
  );

  always_comb begin
    tick_limit = 16'd1;
    unique case (state)
      QUALIFY:  tick_limit = 16'(QUAL_TICKS);
      BEEP_ON:  tick_limit = 16'(ON_TICKS);
      BEEP_OFF: tick_limit = 16'(OFF_TICKS);
      default:  tick_limit = 16'd1;
    endcase
  end

  // The last tick of a state is the one that ends it, so compare against limit-1.
  assign timer_done = tick && (tick_cnt == tick_limit - 16'd1);

  always_comb begin
    next_state = state;
    beep_next  = beep_cnt;
    unique case (state)
      IDLE: begin
        if (warn_in) next_state = QUALIFY;
      end
      QUALIFY: begin
        if (!warn_in) begin
          next_state = IDLE;
        end else if (timer_done) begin
          next_state = BEEP_ON;
          beep_next  = 8'd1;
        end
      end
      BEEP_ON: begin
        if (!warn_in) begin
          next_state = IDLE;
        end else if (ack) begin
          next_state = SILENCED;
        end else if (timer_done) begin
          next_state = (beep_cnt >= 8'(MAX_BEEPS)) ? SILENCED : BEEP_OFF;
        end
      end
      BEEP_OFF: begin
        if (!warn_in) begin
          next_state = IDLE;
        end else if (ack) begin
          next_state = SILENCED;
        end else if (timer_done) begin
          next_state = BEEP_ON;
          if (beep_cnt < 8'(MAX_BEEPS)) beep_next = beep_cnt + 8'd1;
        end
      end
      SILENCED: begin
        if (!warn_in) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (next_state == IDLE) beep_next = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Ticks are only meaningful in the timed states; holding zero elsewhere avoids wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (state_change || state == IDLE || state == SILENCED) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buzzer   <= 1'b0;
      lamp     <= 1'b0;
      silenced <= 1'b0;
      beep_cnt <= '0;
    end else begin
      buzzer   <= (next_state == BEEP_ON);
      lamp     <= (next_state == BEEP_ON) || (next_state == BEEP_OFF) ||
                  (next_state == SILENCED);
      silenced <= (next_state == SILENCED);
      beep_cnt <= beep_next;
    end
  end

endmodule

// File: tb/tb_car_warning_sequencer.sv
// Directed bench for car_warning_sequencer with a queue scoreboard of
// expected {buzzer, lamp, silenced, beep_cnt} per sampled step.
module tb_car_warning_sequencer;

  logic       clk;
  logic       rst_n;
  logic       warn_in;
  logic       ack;
  logic       buzzer;
  logic       lamp;
  logic [7:0] beep_cnt;
  logic       silenced;

  typedef struct packed {
    logic       buz;
    logic       lmp;
    logic       sil;
    logic [7:0] cnt;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    errors = 0;
  int    checks = 0;

  car_warning_sequencer #(
    .PRESCALE   (4),
    .QUAL_TICKS (2),
    .ON_TICKS   (2),
    .OFF_TICKS  (1),
    .MAX_BEEPS  (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .warn_in  (warn_in),
    .ack      (ack),
    .buzzer   (buzzer),
    .lamp     (lamp),
    .beep_cnt (beep_cnt),
    .silenced (silenced)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t o_idle();
    return '{buz: 1'b0, lmp: 1'b0, sil: 1'b0, cnt: 8'd0};
  endfunction
  function automatic obs_t o_on(input int n);
    return '{buz: 1'b1, lmp: 1'b1, sil: 1'b0, cnt: 8'(n)};
  endfunction
  function automatic obs_t o_off(input int n);
    return '{buz: 1'b0, lmp: 1'b1, sil: 1'b0, cnt: 8'(n)};
  endfunction
  function automatic obs_t o_sil(input int n);
    return '{buz: 1'b0, lmp: 1'b1, sil: 1'b1, cnt: 8'(n)};
  endfunction

  task automatic check_front();
    obs_t  e;
    obs_t  got;
    string t;
    e   = exp_q.pop_front();
    t   = tag_q.pop_front();
    got = '{buz: buzzer, lmp: lamp, sil: silenced, cnt: beep_cnt};
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: got buz=%b lamp=%b sil=%b cnt=%0d, expected buz=%b lamp=%b sil=%b cnt=%0d",
             t, got.buz, got.lmp, got.sil, got.cnt, e.buz, e.lmp, e.sil, e.cnt);
    end
  endtask

  // Drive inputs, advance one edge, compare the registered outputs 1 time unit later.
  task automatic cyc(input logic w, input logic a, input obs_t e, input string tag);
    warn_in = w;
    ack     = a;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    warn_in = 1'b0;
    ack     = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(o_idle()); tag_q.push_back("reset_init");
    check_front();
    rst_n = 1'b1;

    // 1: reach BEEP_ON, then reset without a clock edge
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, o_idle(), "r_qualify");
    cyc(1'b1, 1'b0, o_on(1), "r_beep_on");
    cyc(1'b1, 1'b0, o_on(1), "r_beep_on2");
    #2;
    rst_n   = 1'b0;
    warn_in = 1'b0;
    #1;
    exp_q.push_back(o_idle()); tag_q.push_back("async_reset");
    check_front();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, o_idle(), "post_reset_idle");

    // 2: glitch shorter than qualification
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, o_idle(), "glitch_high");
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, o_idle(), "glitch_low");

    // 3: full pattern to auto-silence; ack during QUALIFY must be ignored
    for (int i = 0; i < 8; i++) cyc(1'b1, (i == 3), o_idle(), "full_qualify");
    for (int b = 1; b <= 3; b++) begin
      for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, o_on(b), "full_on");
      if (b < 3) for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, o_off(b), "full_off");
    end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, o_sil(3), "full_silenced");
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, o_idle(), "full_drop");

    // 4: ack in second BEEP_OFF, then ack again in SILENCED
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, o_idle(), "ack_qualify");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, o_on(1), "ack_on1");
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, o_off(1), "ack_off1");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, o_on(2), "ack_on2");
    cyc(1'b1, 1'b0, o_off(2), "ack_off2");
    cyc(1'b1, 1'b1, o_sil(2), "ack_to_silenced");
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, o_sil(2), "ack_hold");
    cyc(1'b1, 1'b1, o_sil(2), "ack_in_silenced");
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, o_sil(2), "ack_hold2");

    // 6: re-arm from SILENCED
    cyc(1'b0, 1'b0, o_idle(), "rearm_low");
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, o_idle(), "rearm_qualify");
    cyc(1'b1, 1'b0, o_on(1), "rearm_beep_on");
    cyc(1'b1, 1'b0, o_on(1), "rearm_beep_on2");

    // 5: warn drop and ack on the same edge in BEEP_ON -> IDLE, not SILENCED
    cyc(1'b0, 1'b1, o_idle(), "simul_drop_ack");
    cyc(1'b0, 1'b1, o_idle(), "ack_in_idle");
    cyc(1'b0, 1'b0, o_idle(), "final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
